// File: rtl/sprite_pkg.sv
// Shared field widths, command layout and writer FSM states for the sprite table writer.
package sprite_pkg;

    localparam int POSX_W = 9;
    localparam int POSY_W = 9;
    localparam int SCL_W  = 4;
    localparam int PAL_W  = 20;
    localparam int BMP_W  = 32;
    localparam int ROW_W  = 4;

    typedef enum logic {
        CMD_ATTR = 1'b0,
        CMD_BMP  = 1'b1
    } cmd_type_e;

    // Sprite index is kept beside this body because its width follows NSPR.
    typedef struct packed {
        cmd_type_e           kind;
        logic [ROW_W-1:0]    row;
        logic [POSY_W-1:0]   pos_y;
        logic [POSX_W-1:0]   pos_x;
        logic [SCL_W-1:0]    scl_x;
        logic                swp_x;
        logic [PAL_W-1:0]    pal;
        logic [BMP_W-1:0]    bmp;
    } cmd_body_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Small synchronous FIFO holding packed sprite commands; head entry is visible on dout.
module sprite_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sprite_table_writer.sv
// Queues sprite attribute/bitmap commands and serialises them into 32-bit video RAM writes.
// Optional SPRITE_WR_VBLANK_ONLY_EN: new commands start only while xvsync is low.
module sprite_table_writer
    import sprite_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] ATTR_BASE  = 16'hF000,
    parameter logic [15:0] BMP_BASE   = 16'hE000,
    parameter int          NSPR       = 8,
    localparam int         IDX_W      = $clog2(NSPR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_type,
    input  logic [IDX_W-1:0]  cmd_idx,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [POSX_W-1:0] cmd_posX,
    input  logic [POSY_W-1:0] cmd_posY,
    input  logic [SCL_W-1:0]  cmd_sclX,
    input  logic              cmd_swpX,
    input  logic [PAL_W-1:0]  cmd_pal,
    input  logic [BMP_W-1:0]  cmd_bmp,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [15:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic              xvsync,
    output logic              busy
);

    localparam int ENTRY_W = IDX_W + $bits(cmd_body_t);

    cmd_body_t          in_cmd;
    cmd_body_t          head_cmd;
    cmd_body_t          cur_cmd;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               full;
    logic               empty;
    logic               pop;
    logic               window;
    wr_state_e          state;
    wr_state_e          state_nxt;

    always_comb begin
        in_cmd       = '0;
        in_cmd.kind  = cmd_type_e'(cmd_type);
        in_cmd.row   = cmd_row;
        in_cmd.pos_y = cmd_posY;
        in_cmd.pos_x = cmd_posX;
        in_cmd.scl_x = cmd_sclX;
        in_cmd.swp_x = cmd_swpX;
        in_cmd.pal   = cmd_pal;
        in_cmd.bmp   = cmd_bmp;
    end

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .din   ({cmd_idx, in_cmd}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign {head_idx, head_cmd} = fifo_dout;
    assign cmd_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);

`ifdef SPRITE_WR_VBLANK_ONLY_EN
    assign window = !xvsync;
`else
    logic unused_xvsync;
    assign unused_xvsync = xvsync;
    assign window = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_idx <= '0;
            cur_cmd <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_idx <= head_idx;
                cur_cmd <= head_cmd;
            end
        end
    end

    // The window gates only the start of a command, so an attribute pair is never split.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ram_req   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (!empty && window) begin
                    pop       = 1'b1;
                    state_nxt = ST_WR0;
                end
            end
            ST_WR0: begin
                ram_req = 1'b1;
                if (cur_cmd.kind == CMD_ATTR) begin
                    ram_addr  = ATTR_BASE + 16'({cur_idx, 1'b0});
                    ram_wdata = {cur_cmd.pos_y, cur_cmd.pos_x, cur_cmd.scl_x, cur_cmd.swp_x,
                                 {(BMP_W-POSY_W-POSX_W-SCL_W-1){1'b0}}};
                end else begin
                    ram_addr  = BMP_BASE + 16'({cur_idx, cur_cmd.row});
                    ram_wdata = cur_cmd.bmp;
                end
                if (ram_gnt) begin
                    if (cur_cmd.kind == CMD_ATTR) begin
                        state_nxt = ST_WR1;
                    end else if (!empty && window) begin
                        pop       = 1'b1;
                        state_nxt = ST_WR0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WR1: begin
                ram_req   = 1'b1;
                ram_addr  = ATTR_BASE + 16'({cur_idx, 1'b1});
                ram_wdata = {{(BMP_W-PAL_W){1'b0}}, cur_cmd.pal};
                if (ram_gnt) begin
                    if (!empty && window) begin
                        pop       = 1'b1;
                        state_nxt = ST_WR0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sprite_table_writer.sv
// Scoreboard bench for sprite_table_writer: expected RAM writes are queued at command acceptance.
`timescale 1ns/1ps
module tb_sprite_table_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_type = 1'b0;
    logic [2:0]  cmd_idx = '0;
    logic [3:0]  cmd_row = '0;
    logic [8:0]  cmd_posX = '0;
    logic [8:0]  cmd_posY = '0;
    logic [3:0]  cmd_sclX = '0;
    logic        cmd_swpX = 1'b0;
    logic [19:0] cmd_pal = '0;
    logic [31:0] cmd_bmp = '0;
    logic        ram_gnt = 1'b0;
    logic        xvsync = 1'b0;
    logic        cmd_ready;
    logic        ram_req;
    logic        busy;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;

    logic        w_valid = 1'b0;
    logic        w_gnt = 1'b1;
    logic        w_ready;
    logic        w_req;
    logic        w_busy;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;

    int          compared = 0;
    int          mismatched = 0;
    logic [47:0] sb[$];

    sprite_table_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_idx(cmd_idx), .cmd_row(cmd_row),
        .cmd_posX(cmd_posX), .cmd_posY(cmd_posY), .cmd_sclX(cmd_sclX),
        .cmd_swpX(cmd_swpX), .cmd_pal(cmd_pal), .cmd_bmp(cmd_bmp),
        .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .xvsync(xvsync), .busy(busy)
    );

    sprite_table_writer #(.ATTR_BASE(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst), .cmd_valid(w_valid), .cmd_ready(w_ready),
        .cmd_type(cmd_type), .cmd_idx(cmd_idx), .cmd_row(cmd_row),
        .cmd_posX(cmd_posX), .cmd_posY(cmd_posY), .cmd_sclX(cmd_sclX),
        .cmd_swpX(cmd_swpX), .cmd_pal(cmd_pal), .cmd_bmp(cmd_bmp),
        .ram_req(w_req), .ram_gnt(w_gnt), .ram_addr(w_addr),
        .ram_wdata(w_wdata), .xvsync(xvsync), .busy(w_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] attrWord0(input logic [15:0] base, input logic [2:0] idx,
                                              input logic [8:0] px, input logic [8:0] py,
                                              input logic [3:0] s, input logic sw);
        logic [15:0] a;
        a = base + {12'd0, idx, 1'b0};
        return {a, py, px, s, sw, 9'd0};
    endfunction

    function automatic logic [47:0] attrWord1(input logic [15:0] base, input logic [2:0] idx,
                                              input logic [19:0] pal);
        logic [15:0] a;
        a = base + {12'd0, idx, 1'b1};
        return {a, 12'd0, pal};
    endfunction

    function automatic logic [47:0] bmpWord(input logic [2:0] idx, input logic [3:0] row,
                                            input logic [31:0] bmp);
        logic [15:0] a;
        a = 16'hE000 + {9'd0, idx, row};
        return {a, bmp};
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one command on the main DUT and queue the writes it must produce.
    task automatic applyStimulus(input logic typ, input logic [2:0] idx, input logic [3:0] row,
                                 input logic [8:0] px, input logic [8:0] py, input logic [3:0] s,
                                 input logic sw, input logic [19:0] pal, input logic [31:0] bmp);
        int n = 0;
        cmd_type = typ; cmd_idx = idx; cmd_row = row; cmd_posX = px; cmd_posY = py;
        cmd_sclX = s; cmd_swpX = sw; cmd_pal = pal; cmd_bmp = bmp;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept", 48'(cmd_ready), 48'd1);
        if (cmd_ready) begin
            if (typ == 1'b0) begin
                sb.push_back(attrWord0(16'hF000, idx, px, py, s, sw));
                sb.push_back(attrWord1(16'hF000, idx, pal));
            end else begin
                sb.push_back(bmpWord(idx, row, bmp));
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle", 48'(busy), 48'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && ram_req && ram_gnt) begin
            checkOutput("sb_has_entry", 48'(sb.size() != 0), 48'd1);
            if (sb.size() != 0)
                checkOutput("write", {ram_addr, ram_wdata}, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 48'(cmd_ready), 48'd1);
        checkOutput("rst_req", 48'(ram_req), 48'd0);
        checkOutput("rst_addr", 48'(ram_addr), 48'd0);
        checkOutput("rst_wdata", 48'(ram_wdata), 48'd0);
        checkOutput("rst_busy", 48'(busy), 48'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Attribute command with grant tied high; also checks two-cycle issue latency.
        ram_gnt = 1'b1;
        applyStimulus(1'b0, 3'd3, 4'd0, 9'h105, 9'h0A0, 4'd2, 1'b1, 20'hABCDE, 32'd0);
        checkOutput("t2_lat_low", 48'(ram_req), 48'd0);
        @(posedge clk); #1;
        checkOutput("t2_req", 48'(ram_req), 48'd1);
        checkOutput("t2_addr0", 48'(ram_addr), 48'h00F006);
        @(posedge clk); #1;
        checkOutput("t2_addr1", 48'(ram_addr), 48'h00F007);
        @(posedge clk); #1;
        checkOutput("t2_req_drop", 48'(ram_req), 48'd0);
        checkOutput("t2_busy", 48'(busy), 48'd0);

        // Bitmap row with the grant withheld for three cycles.
        ram_gnt = 1'b0;
        applyStimulus(1'b1, 3'd5, 4'd15, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'hDEADBEEF);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_hold_req", 48'(ram_req), 48'd1);
            checkOutput("t3_hold_word", {ram_addr, ram_wdata}, bmpWord(3'd5, 4'd15, 32'hDEADBEEF));
            @(posedge clk); #1;
        end
        ram_gnt = 1'b1;
        @(posedge clk); #1;
        ram_gnt = 1'b0;
        checkOutput("t3_req_drop", 48'(ram_req), 48'd0);
        checkOutput("t3_sb_empty", 48'(sb.size()), 48'd0);

        // Back-pressure: one command parked in WR0 plus a full queue.
        applyStimulus(1'b0, 3'd0, 4'd0, 9'h011, 9'h022, 4'd1, 1'b0, 20'h13579, 32'd0);
        applyStimulus(1'b1, 3'd1, 4'd2, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'h01234567);
        applyStimulus(1'b0, 3'd7, 4'd0, 9'h1FF, 9'h100, 4'd15, 1'b1, 20'hFFFFF, 32'd0);
        applyStimulus(1'b1, 3'd2, 4'd0, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'hA5A5F00F);
        applyStimulus(1'b1, 3'd6, 4'd9, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'h80000001);
        checkOutput("t4_ready_low", 48'(cmd_ready), 48'd0);
        checkOutput("t4_busy", 48'(busy), 48'd1);
        ram_gnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checkOutput("t4_no_gap", 48'(ram_req), 48'd1);
            @(posedge clk); #1;
        end
        checkOutput("t4_req_drop", 48'(ram_req), 48'd0);
        checkOutput("t4_sb_empty", 48'(sb.size()), 48'd0);

`ifdef SPRITE_WR_VBLANK_ONLY_EN
        // Writes start only in vblank; an attribute pair finishes once started.
        xvsync = 1'b1;
        applyStimulus(1'b0, 3'd4, 4'd0, 9'h033, 9'h044, 4'd3, 1'b1, 20'h2468A, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("t5_blocked", 48'(ram_req), 48'd0);
        checkOutput("t5_busy", 48'(busy), 48'd1);
        xvsync = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_req", 48'(ram_req), 48'd1);
        xvsync = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5_wr1_req", 48'(ram_req), 48'd1);
        checkOutput("t5_wr1_addr", 48'(ram_addr), 48'h00F009);
        @(posedge clk); #1;
        checkOutput("t5_done", 48'(ram_req), 48'd0);
        xvsync = 1'b0;
`else
        // Without the vblank gate xvsync has no effect.
        xvsync = 1'b1;
        applyStimulus(1'b1, 3'd4, 4'd7, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'h5A5A1234);
        waitIdle(50);
        checkOutput("t5_sb_empty", 48'(sb.size()), 48'd0);
        xvsync = 1'b0;
`endif

        // Reset in the middle of a write drops the request and the queue.
        ram_gnt = 1'b0;
        applyStimulus(1'b0, 3'd2, 4'd0, 9'h0AA, 9'h055, 4'd5, 1'b0, 20'h11111, 32'd0);
        applyStimulus(1'b1, 3'd3, 4'd1, 9'd0, 9'd0, 4'd0, 1'b0, 20'd0, 32'hCAFEF00D);
        checkOutput("t1_req_before", 48'(ram_req), 48'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_req_async", 48'(ram_req), 48'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t1_ready", 48'(cmd_ready), 48'd1);
        checkOutput("t1_busy", 48'(busy), 48'd0);
        ram_gnt = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("t1_no_write", 48'(ram_req), 48'd0);

        // Attribute address arithmetic wraps at 16 bits.
        cmd_type = 1'b0; cmd_idx = 3'd1; cmd_posX = 9'h1FF; cmd_posY = 9'h003;
        cmd_sclX = 4'hF; cmd_swpX = 1'b0; cmd_pal = 20'h12345;
        w_valid = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0;
        n = 0;
        while (!w_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t6_req", 48'(w_req), 48'd1);
        checkOutput("t6_addr0", 48'(w_addr), 48'h000000);
        checkOutput("t6_word0", {w_addr, w_wdata}, attrWord0(16'hFFFE, 3'd1, 9'h1FF, 9'h003, 4'hF, 1'b0));
        @(posedge clk); #1;
        checkOutput("t6_word1", {w_addr, w_wdata}, attrWord1(16'hFFFE, 3'd1, 20'h12345));
        @(posedge clk); #1;
        checkOutput("t6_done", 48'(w_req), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
